// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: ALU control codes (base ALU plus M extension)
// and the multiply/divide unit state encoding.
package rv32_pkg;

   typedef enum logic [4:0] {
      ALU_ADD    = 5'b00000,
      ALU_SUB    = 5'b00001,
      ALU_SLL    = 5'b00010,
      ALU_SLT    = 5'b00011,
      ALU_SLTU   = 5'b00100,
      ALU_XOR    = 5'b00101,
      ALU_SRL    = 5'b00110,
      ALU_SRA    = 5'b00111,
      ALU_OR     = 5'b01000,
      ALU_AND    = 5'b01001,
      ALU_LUI    = 5'b01010,
      ALU_MUL    = 5'b01011,
      ALU_MULH   = 5'b01100,
      ALU_MULHSU = 5'b01101,
      ALU_MULHU  = 5'b01110,
      ALU_DIV    = 5'b01111,
      ALU_DIVU   = 5'b10000,
      ALU_REM    = 5'b10001,
      ALU_REMU   = 5'b10010
   } alu_ctrl_t;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_FIX  = 2'd2,
      MD_DONE = 2'd3
   } muldiv_state_t;

   // Counter value in the last of the 32 CALC iterations.
   localparam logic [5:0] MD_ITER_LAST = 6'd31;

   function automatic logic is_muldiv(input alu_ctrl_t op);
      return (op >= ALU_MUL) && (op <= ALU_REMU);
   endfunction

   function automatic logic is_mul(input alu_ctrl_t op);
      return (op >= ALU_MUL) && (op <= ALU_MULHU);
   endfunction

   function automatic logic is_sdiv(input alu_ctrl_t op);
      return (op == ALU_DIV) || (op == ALU_REM);
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Operands are reduced to magnitudes
// at accept; a 64-bit accumulator is shared between shift-add multiply and
// restoring division, and the sign is applied once in FIX.
module muldiv_unit
   import rv32_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [4:0]      alu_ctrl,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   muldiv_state_t     state_q, state_d;
   logic [5:0]        cnt_q;
   logic [2*XLEN-1:0] acc_q;
   logic [XLEN-1:0]   opx_q;      // multiplicand or divisor magnitude
   alu_ctrl_t         op_q;
   logic              negq_q;     // product / quotient must be negated
   logic              negr_q;     // remainder must be negated
   logic [XLEN-1:0]   result_q;

   alu_ctrl_t         op_in;
   logic              accept, special;
   logic              a_neg, b_neg;
   logic [XLEN-1:0]   a_mag, b_mag, special_val, fix_val;
   logic              div0, ovf;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo, rem;

   function automatic logic [2*XLEN-1:0] cond_neg_w(input logic [2*XLEN-1:0] v, input logic neg);
      return neg ? (~v + {{(2*XLEN-1){1'b0}}, 1'b1}) : v;
   endfunction

   function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
      return neg ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
   endfunction

   // Shift-add step: multiplier sits in the low half and is consumed LSB first.
   function automatic logic [2*XLEN-1:0] mul_step(input logic [2*XLEN-1:0] acc, input logic [XLEN-1:0] m);
      logic [XLEN:0] sum;
      sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? m : {XLEN{1'b0}})};
      return {sum, acc[XLEN-1:1]};
   endfunction

   // Restoring step: partial remainder in the high half, quotient bits shift in low.
   function automatic logic [2*XLEN-1:0] div_step(input logic [2*XLEN-1:0] acc, input logic [XLEN-1:0] d);
      logic [XLEN:0] trial, diff;
      trial = acc[2*XLEN-1:XLEN-1];
      diff  = trial - {1'b0, d};
      if (!diff[XLEN])
         return {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else
         return {acc[2*XLEN-2:0], 1'b0};
   endfunction

   // Accept-time decode: signs, magnitudes and special-case detection.
   always_comb begin
      op_in   = alu_ctrl_t'(alu_ctrl);
      a_neg   = op_a[XLEN-1] & (is_mul(op_in) ? (op_in != ALU_MULHU) : is_sdiv(op_in));
      b_neg   = op_b[XLEN-1] & ((op_in == ALU_MUL) || (op_in == ALU_MULH) || is_sdiv(op_in));
      a_mag   = cond_neg(op_a, a_neg);
      b_mag   = cond_neg(op_b, b_neg);
      div0    = is_muldiv(op_in) && !is_mul(op_in) && (op_b == '0);
      ovf     = is_sdiv(op_in) && (op_a == INT_MIN) && (op_b == '1);
      special = div0 || ovf;
      special_val = '0;
      if (div0)
         special_val = ((op_in == ALU_DIV) || (op_in == ALU_DIVU)) ? '1 : op_a;
      else if (ovf)
         special_val = (op_in == ALU_DIV) ? INT_MIN : '0;
      accept = (state_q == MD_IDLE) && start && is_muldiv(op_in);
   end

   // Sign correction and result selection used in FIX.
   always_comb begin
      prod = cond_neg_w(acc_q, negq_q);
      quo  = cond_neg(acc_q[XLEN-1:0], negq_q);
      rem  = cond_neg(acc_q[2*XLEN-1:XLEN], negr_q);
      case (op_q)
         ALU_MUL:                          fix_val = prod[XLEN-1:0];
         ALU_MULH, ALU_MULHSU, ALU_MULHU:  fix_val = prod[2*XLEN-1:XLEN];
         ALU_DIV, ALU_DIVU:                fix_val = quo;
         ALU_REM, ALU_REMU:                fix_val = rem;
         default:                          fix_val = '0;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= MD_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic and handshake outputs.
   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         MD_IDLE: if (accept) state_d = special ? MD_DONE : MD_CALC;
         MD_CALC: begin
            busy = 1'b1;
            if (cnt_q == MD_ITER_LAST) state_d = MD_FIX;
         end
         MD_FIX: begin
            busy    = 1'b1;
            state_d = MD_DONE;
         end
         MD_DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = MD_IDLE;
         end
         default: state_d = MD_IDLE;
      endcase
   end

   // Datapath: operand capture, iteration, and result register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         acc_q    <= '0;
         opx_q    <= '0;
         op_q     <= ALU_ADD;
         negq_q   <= 1'b0;
         negr_q   <= 1'b0;
         result_q <= '0;
      end else begin
         case (state_q)
            MD_IDLE: if (accept) begin
               op_q   <= op_in;
               cnt_q  <= '0;
               acc_q  <= {{XLEN{1'b0}}, (is_mul(op_in) ? b_mag : a_mag)};
               opx_q  <= is_mul(op_in) ? a_mag : b_mag;
               negq_q <= a_neg ^ b_neg;
               negr_q <= a_neg;
               if (special) result_q <= special_val;
            end
            MD_CALC: begin
               cnt_q <= cnt_q + 6'd1;
               acc_q <= is_mul(op_q) ? mul_step(acc_q, opx_q) : div_step(acc_q, opx_q);
            end
            MD_FIX:  result_q <= fix_val;
            default: ;
         endcase
      end
   end

   assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: table-driven vectors with a
// scoreboard queue, plus hand-written handshake and reset-abort sequences.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [4:0]  alu_ctrl = '0;
   logic [31:0] op_a = '0, op_b = '0;
   logic        busy, done;
   logic [31:0] result;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   localparam logic [4:0] C_MUL = 5'b01011, C_MULH = 5'b01100, C_MULHSU = 5'b01101,
                          C_MULHU = 5'b01110, C_DIV = 5'b01111, C_DIVU = 5'b10000,
                          C_REM = 5'b10001, C_REMU = 5'b10010;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   typedef struct {
      logic [31:0] exp;
      int          lat;
      int          cyc0;
   } sb_t;

   sb_t sb[$];

   muldiv_unit #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .start(start), .alu_ctrl(alu_ctrl),
      .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Scoreboard: every done pops one expected record.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
         end else begin
            sb_t e;
            e = sb.pop_front();
            check("result", result, e.exp);
            check("latency", 32'(cyc - e.cyc0), 32'(e.lat));
         end
      end
   end

   // Issue one op; optionally poke a second start in busy cycle 'poke'.
   task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input int poke);
      int nb;
      sb_t e;
      @(negedge clk);
      start = 1'b1; alu_ctrl = op; op_a = a; op_b = b;
      e.exp = exp; e.lat = lat; e.cyc0 = cyc;
      sb.push_back(e);
      nb = 0;
      for (int k = 1; k <= 80; k++) begin
         @(negedge clk);
         if (!busy) begin
            start = 1'b0;
            break;
         end
         nb++;
         start = (k == poke);
         if (k == poke) begin
            alu_ctrl = C_DIVU; op_a = 32'd1000; op_b = 32'd3;
         end else begin
            op_a = $urandom; op_b = $urandom;
         end
      end
      start = 1'b0;
      check("busy_cycles", 32'(nb), 32'(lat));
      @(negedge clk);
      check("result_hold", result, exp);
   endtask

   vec_t tbl[16];

   initial begin
      tbl[0]  = '{C_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34};
      tbl[1]  = '{C_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34};
      tbl[2]  = '{C_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34};
      tbl[3]  = '{C_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34};
      tbl[4]  = '{C_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34};
      tbl[5]  = '{C_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34};
      tbl[6]  = '{C_DIVU,   32'd100,      32'd7,        32'h0000000E, 34};
      tbl[7]  = '{C_REMU,   32'd100,      32'd7,        32'h00000002, 34};
      tbl[8]  = '{C_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1};
      tbl[9]  = '{C_REM,    32'd5,        32'd0,        32'd5,        1};
      tbl[10] = '{C_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
      tbl[11] = '{C_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
      tbl[12] = '{C_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'd0,        34};
      tbl[13] = '{C_REMU,   32'h12345678, 32'd0,        32'h12345678, 1};
      tbl[14] = '{C_MUL,    32'h00010000, 32'h00010000, 32'd0,        34};
      tbl[15] = '{C_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        34};

      // Reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", result, 32'd0);

      // Table-driven vectors
      for (int i = 0; i < 16; i++)
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat, 0);

      // Non-M code with start: ignored
      @(negedge clk);
      start = 1'b1; alu_ctrl = 5'b00000; op_a = 32'd9; op_b = 32'd9;
      @(negedge clk);
      start = 1'b0;
      check("badcode_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      check("badcode_busy_later", 32'(busy), 32'd0);
      check("badcode_result", result, 32'd1);

      // Second start in busy cycle 5 of a MUL, then start in the DONE cycle
      run_op(C_MUL, 32'd6, 32'd7, 32'd42, 34, 5);
      run_op(C_MULHU, 32'h00000002, 32'h80000000, 32'd1, 34, 34);
      repeat (3) @(negedge clk);
      check("done_cycle_start_busy", 32'(busy), 32'd0);

      // Reset abort in cycle 10 of a DIVU
      @(negedge clk);
      start = 1'b1; alu_ctrl = C_DIVU; op_a = 32'd1000; op_b = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_result", result, 32'd0);
      repeat (40) @(negedge clk);
      run_op(C_MUL, 32'd3, 32'd4, 32'd12, 34, 0);

      repeat (3) @(negedge clk);
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
